// File: rtl/ex_stage_if.sv
// ID/EX-side inputs, forwarding selects and EX/MEM-side outputs of the execute stage.
// Ovf_o exists only when EX_OVF_TRAP_EN is defined.
interface ex_stage_if #(
  parameter int WIDTH = 32
);
  logic             Flush_i;
  logic             IDEX_Valid_i;
  logic [2:0]       IDEX_ALUOp_i;
  logic             IDEX_ALUSrc_i;
  logic [WIDTH-1:0] IDEX_RSData_i;
  logic [WIDTH-1:0] IDEX_RTData_i;
  logic [WIDTH-1:0] IDEX_Imm_i;
  logic [4:0]       IDEX_RD_i;
  logic             IDEX_RegWrite_i;
  logic             IDEX_MemRead_i;
  logic             IDEX_MemWrite_i;
  logic             IDEX_MemtoReg_i;
  logic [1:0]       Forward1_i;
  logic [1:0]       Forward2_i;
  logic [WIDTH-1:0] EXMEM_FwdData_i;
  logic [WIDTH-1:0] MEMWB_FwdData_i;
  logic             Stall_o;
  logic [WIDTH-1:0] EXMEM_ALUResult_o;
  logic [WIDTH-1:0] EXMEM_WriteData_o;
  logic [4:0]       EXMEM_RD_o;
  logic             EXMEM_RegWrite_o;
  logic             EXMEM_MemRead_o;
  logic             EXMEM_MemWrite_o;
  logic             EXMEM_MemtoReg_o;
`ifdef EX_OVF_TRAP_EN
  logic             Ovf_o;
`endif

  modport master (
    output Flush_i, IDEX_Valid_i, IDEX_ALUOp_i, IDEX_ALUSrc_i, IDEX_RSData_i,
           IDEX_RTData_i, IDEX_Imm_i, IDEX_RD_i, IDEX_RegWrite_i, IDEX_MemRead_i,
           IDEX_MemWrite_i, IDEX_MemtoReg_i, Forward1_i, Forward2_i,
           EXMEM_FwdData_i, MEMWB_FwdData_i,
`ifdef EX_OVF_TRAP_EN
    input  Ovf_o,
`endif
    input  Stall_o, EXMEM_ALUResult_o, EXMEM_WriteData_o, EXMEM_RD_o,
           EXMEM_RegWrite_o, EXMEM_MemRead_o, EXMEM_MemWrite_o, EXMEM_MemtoReg_o
  );

  modport slave (
    input  Flush_i, IDEX_Valid_i, IDEX_ALUOp_i, IDEX_ALUSrc_i, IDEX_RSData_i,
           IDEX_RTData_i, IDEX_Imm_i, IDEX_RD_i, IDEX_RegWrite_i, IDEX_MemRead_i,
           IDEX_MemWrite_i, IDEX_MemtoReg_i, Forward1_i, Forward2_i,
           EXMEM_FwdData_i, MEMWB_FwdData_i,
`ifdef EX_OVF_TRAP_EN
    output Ovf_o,
`endif
    output Stall_o, EXMEM_ALUResult_o, EXMEM_WriteData_o, EXMEM_RD_o,
           EXMEM_RegWrite_o, EXMEM_MemRead_o, EXMEM_MemWrite_o, EXMEM_MemtoReg_o
  );
endinterface

// File: rtl/ex_stage.sv
// MIPS execute stage: operand forwarding, ALU, iterative shift-add MUL and the EX/MEM register.
// Optional signed-overflow trap on ADD/SUB is enabled by defining EX_OVF_TRAP_EN.
module ex_stage #(
  parameter int WIDTH = 32
) (
  input logic       clk_i,
  input logic       rst_i,
  ex_stage_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] mul_a_reg, mul_b_reg, acc_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] alu_result_reg, write_data_reg;
  logic [4:0]       rd_reg;
  logic             reg_write_reg, mem_read_reg, mem_write_reg, mem_to_reg_reg;

  logic [WIDTH-1:0] op_a, fwd_b, op_b, sum, diff, alu_result;
  logic             is_mul, slt;
  logic [WIDTH-1:0] alu_result_next, write_data_next;
  logic [4:0]       rd_next;
  logic             reg_write_next, mem_read_next, mem_write_next, mem_to_reg_next;

`ifdef EX_OVF_TRAP_EN
  logic ovf_reg, ovf_next, ovf;
`endif

  always_comb begin
    case (bus.Forward1_i)
      2'b10:   op_a = bus.EXMEM_FwdData_i;
      2'b01:   op_a = bus.MEMWB_FwdData_i;
      default: op_a = bus.IDEX_RSData_i;
    endcase
    case (bus.Forward2_i)
      2'b10:   fwd_b = bus.EXMEM_FwdData_i;
      2'b01:   fwd_b = bus.MEMWB_FwdData_i;
      default: fwd_b = bus.IDEX_RTData_i;
    endcase
    op_b = bus.IDEX_ALUSrc_i ? bus.IDEX_Imm_i : fwd_b;
  end

  assign sum    = op_a + op_b;
  assign diff   = op_a - op_b;
  assign slt    = $signed(op_a) < $signed(op_b);
  assign is_mul = (bus.IDEX_ALUOp_i == 3'b011);

  always_comb begin
    case (bus.IDEX_ALUOp_i)
      3'b000:  alu_result = op_a & op_b;
      3'b001:  alu_result = op_a | op_b;
      3'b110:  alu_result = diff;
      3'b111:  alu_result = {{(WIDTH-1){1'b0}}, slt};
      default: alu_result = sum;
    endcase
  end

`ifdef EX_OVF_TRAP_EN
  always_comb begin
    case (bus.IDEX_ALUOp_i)
      3'b010, 3'b100, 3'b101:
        ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
      3'b110:
        ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

  // Held low under reset so the hazard unit never sees a stall from random ID/EX contents.
  assign bus.Stall_o = rst_i & ~bus.Flush_i &
                       (((state_reg == IDLE) & bus.IDEX_Valid_i & is_mul) | (state_reg == BUSY));

  // EX/MEM next value: a bubble unless a single-cycle op issues or a finished MUL retires.
  always_comb begin
    alu_result_next = '0;
    write_data_next = '0;
    rd_next         = '0;
    reg_write_next  = 1'b0;
    mem_read_next   = 1'b0;
    mem_write_next  = 1'b0;
    mem_to_reg_next = 1'b0;
`ifdef EX_OVF_TRAP_EN
    ovf_next        = 1'b0;
`endif
    if (!bus.Flush_i && bus.IDEX_Valid_i) begin
      if ((state_reg == IDLE && !is_mul) || state_reg == DONE) begin
        alu_result_next = (state_reg == DONE) ? acc_reg : alu_result;
        write_data_next = fwd_b;
        rd_next         = bus.IDEX_RD_i;
        reg_write_next  = bus.IDEX_RegWrite_i;
        mem_read_next   = bus.IDEX_MemRead_i;
        mem_write_next  = bus.IDEX_MemWrite_i;
        mem_to_reg_next = bus.IDEX_MemtoReg_i;
`ifdef EX_OVF_TRAP_EN
        if (state_reg == IDLE && ovf) begin
          ovf_next       = 1'b1;
          reg_write_next = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg      <= IDLE;
      mul_a_reg      <= '0;
      mul_b_reg      <= '0;
      acc_reg        <= '0;
      cnt_reg        <= '0;
      alu_result_reg <= '0;
      write_data_reg <= '0;
      rd_reg         <= '0;
      reg_write_reg  <= 1'b0;
      mem_read_reg   <= 1'b0;
      mem_write_reg  <= 1'b0;
      mem_to_reg_reg <= 1'b0;
`ifdef EX_OVF_TRAP_EN
      ovf_reg        <= 1'b0;
`endif
    end else begin
      alu_result_reg <= alu_result_next;
      write_data_reg <= write_data_next;
      rd_reg         <= rd_next;
      reg_write_reg  <= reg_write_next;
      mem_read_reg   <= mem_read_next;
      mem_write_reg  <= mem_write_next;
      mem_to_reg_reg <= mem_to_reg_next;
`ifdef EX_OVF_TRAP_EN
      ovf_reg        <= ovf_next;
`endif
      if (bus.Flush_i) begin
        state_reg <= IDLE;
      end else begin
        case (state_reg)
          IDLE: if (bus.IDEX_Valid_i && is_mul) begin
            // Operands are captured after forwarding; the forward sources move on during the stall.
            mul_a_reg <= op_a;
            mul_b_reg <= op_b;
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= BUSY;
          end
          BUSY: begin
            if (mul_b_reg[0]) acc_reg <= acc_reg + mul_a_reg;
            mul_a_reg <= mul_a_reg << 1;
            mul_b_reg <= mul_b_reg >> 1;
            cnt_reg   <= cnt_reg + CW'(1);
            if (cnt_reg == CW'(WIDTH - 1)) state_reg <= DONE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign bus.EXMEM_ALUResult_o = alu_result_reg;
  assign bus.EXMEM_WriteData_o = write_data_reg;
  assign bus.EXMEM_RD_o        = rd_reg;
  assign bus.EXMEM_RegWrite_o  = reg_write_reg;
  assign bus.EXMEM_MemRead_o   = mem_read_reg;
  assign bus.EXMEM_MemWrite_o  = mem_write_reg;
  assign bus.EXMEM_MemtoReg_o  = mem_to_reg_reg;
`ifdef EX_OVF_TRAP_EN
  assign bus.Ovf_o             = ovf_reg;
`endif
endmodule

// File: tb/tb_ex_stage.sv
// Directed testbench for ex_stage: reset, forwarding, ALU ops, multi-cycle MUL, flush and bubbles.
// Builds with or without EX_OVF_TRAP_EN; overflow expectations follow the macro.
module tb_ex_stage;
  localparam int WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  ex_stage_if #(.WIDTH(WIDTH)) bus ();
  ex_stage #(.WIDTH(WIDTH)) dut (.clk_i(clk_i), .rst_i(rst_i), .bus(bus));

  always #5 clk_i = ~clk_i;

  task automatic drive_nop();
    bus.Flush_i = 0; bus.IDEX_Valid_i = 0; bus.IDEX_ALUOp_i = 3'b000; bus.IDEX_ALUSrc_i = 0;
    bus.IDEX_RSData_i = 0; bus.IDEX_RTData_i = 0; bus.IDEX_Imm_i = 0; bus.IDEX_RD_i = 0;
    bus.IDEX_RegWrite_i = 0; bus.IDEX_MemRead_i = 0; bus.IDEX_MemWrite_i = 0; bus.IDEX_MemtoReg_i = 0;
    bus.Forward1_i = 0; bus.Forward2_i = 0; bus.EXMEM_FwdData_i = 0; bus.MEMWB_FwdData_i = 0;
  endtask

  task automatic drive_op(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          input logic [4:0] rd);
    drive_nop();
    bus.IDEX_Valid_i = 1; bus.IDEX_RegWrite_i = 1; bus.IDEX_ALUOp_i = op;
    bus.IDEX_RSData_i = rs; bus.IDEX_RTData_i = rt; bus.IDEX_RD_i = rd;
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      bus.Flush_i = 1'($urandom); bus.IDEX_Valid_i = 1; bus.IDEX_ALUOp_i = 3'($urandom);
      if (i == 0) bus.IDEX_ALUOp_i = 3'b011;
      bus.IDEX_ALUSrc_i = 1'($urandom); bus.IDEX_RSData_i = $urandom; bus.IDEX_RTData_i = $urandom;
      bus.IDEX_Imm_i = $urandom; bus.IDEX_RD_i = 5'($urandom); bus.IDEX_RegWrite_i = 1;
      bus.IDEX_MemRead_i = 1; bus.IDEX_MemWrite_i = 1; bus.IDEX_MemtoReg_i = 1;
      bus.Forward1_i = 2'($urandom); bus.Forward2_i = 2'($urandom);
      bus.EXMEM_FwdData_i = $urandom; bus.MEMWB_FwdData_i = $urandom;
      if (i == 0) bus.Flush_i = 0;
      #1;
      n_checks++;
      if (bus.Stall_o !== 1'b0) begin
        n_fail++; $display("FAIL reset_stall: got %b expected 0", bus.Stall_o);
      end
      n_checks++;
      if ({bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o, bus.EXMEM_RD_o, bus.EXMEM_RegWrite_o,
           bus.EXMEM_MemRead_o, bus.EXMEM_MemWrite_o, bus.EXMEM_MemtoReg_o} !== '0) begin
        n_fail++; $display("FAIL reset_exmem: result %h wdata %h rd %0d ctl %b%b%b%b expected all 0",
          bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o, bus.EXMEM_RD_o, bus.EXMEM_RegWrite_o,
          bus.EXMEM_MemRead_o, bus.EXMEM_MemWrite_o, bus.EXMEM_MemtoReg_o);
      end
      $display("reset cycle %0d checked", i);
    end
    @(negedge clk_i);
    drive_nop();
    rst_i = 1;
    @(negedge clk_i);
    drive_op(3'b010, 32'd3, 32'd4, 5'd7);
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'd7 || bus.EXMEM_RegWrite_o !== 1'b1 || bus.EXMEM_RD_o !== 5'd7) begin
      n_fail++; $display("FAIL first_add: result %h rw %b rd %0d expected 00000007 1 7",
        bus.EXMEM_ALUResult_o, bus.EXMEM_RegWrite_o, bus.EXMEM_RD_o);
    end
    $display("first ADD 3+4 -> %h", bus.EXMEM_ALUResult_o);
    drive_nop();
  endtask

  task automatic test_forwarding();
    drive_op(3'b110, 32'd1, 32'd5, 5'd3);
    bus.EXMEM_FwdData_i = 32'h10; bus.MEMWB_FwdData_i = 32'h20;
    bus.Forward1_i = 2'b10; bus.Forward2_i = 2'b01;
    bus.IDEX_MemWrite_i = 1;
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'hFFFF_FFF0 || bus.EXMEM_WriteData_o !== 32'h20) begin
      n_fail++; $display("FAIL fwd_sub: result %h wdata %h expected fffffff0 00000020",
        bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o);
    end
    n_checks++;
    if (bus.EXMEM_MemWrite_o !== 1'b1 || bus.EXMEM_RD_o !== 5'd3) begin
      n_fail++; $display("FAIL fwd_ctl: memwrite %b rd %0d expected 1 3", bus.EXMEM_MemWrite_o, bus.EXMEM_RD_o);
    end
    $display("forward 10/01 SUB -> %h wdata %h", bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o);
    bus.Forward1_i = 2'b11; bus.Forward2_i = 2'b11;
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'hFFFF_FFFC || bus.EXMEM_WriteData_o !== 32'd5) begin
      n_fail++; $display("FAIL fwd_11: result %h wdata %h expected fffffffc 00000005",
        bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o);
    end
    $display("forward 11/11 SUB -> %h wdata %h", bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o);
    bus.Forward1_i = 2'b01; bus.Forward2_i = 2'b10; bus.IDEX_ALUOp_i = 3'b010;
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'h30 || bus.EXMEM_WriteData_o !== 32'h10) begin
      n_fail++; $display("FAIL fwd_01_10: result %h wdata %h expected 00000030 00000010",
        bus.EXMEM_ALUResult_o, bus.EXMEM_WriteData_o);
    end
    $display("forward 01/10 ADD -> %h", bus.EXMEM_ALUResult_o);
    drive_nop();
  endtask

  task automatic test_mul();
    int  stall_cnt;
    bit  bubble_bad;
    stall_cnt  = 0;
    bubble_bad = 0;
    drive_op(3'b011, 32'hAAAA_AAAA, 32'd5, 5'd9);
    bus.Forward1_i = 2'b10; bus.EXMEM_FwdData_i = 32'h0001_0003;
    #1;
    n_checks++;
    if (bus.Stall_o !== 1'b1) begin
      n_fail++; $display("FAIL mul_start_stall: got %b expected 1", bus.Stall_o);
    end
    if (bus.Stall_o === 1'b1) stall_cnt = 1;
    for (int i = 0; i < 100 && bus.Stall_o === 1'b1; i++) begin
      tick();
      if (bus.EXMEM_RegWrite_o !== 1'b0 || bus.EXMEM_RD_o !== 5'd0) bubble_bad = 1;
      if (bus.Stall_o === 1'b1) stall_cnt++;
      if (stall_cnt == 5) bus.EXMEM_FwdData_i = 32'hDEAD_BEEF;
    end
    n_checks++;
    if (stall_cnt != WIDTH + 1) begin
      n_fail++; $display("FAIL mul_stall_len: got %0d cycles expected %0d", stall_cnt, WIDTH + 1);
    end
    n_checks++;
    if (bubble_bad) begin
      n_fail++; $display("FAIL mul_bubbles: EX/MEM not a bubble during stall, got rw=1 expected rw=0");
    end
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'h0005_000F || bus.EXMEM_RegWrite_o !== 1'b1 || bus.EXMEM_RD_o !== 5'd9) begin
      n_fail++; $display("FAIL mul_result: result %h rw %b rd %0d expected 0005000f 1 9",
        bus.EXMEM_ALUResult_o, bus.EXMEM_RegWrite_o, bus.EXMEM_RD_o);
    end
    $display("MUL 00010003*5 -> %h after %0d stall cycles", bus.EXMEM_ALUResult_o, stall_cnt);
    drive_nop();
    #1;
    n_checks++;
    if (bus.Stall_o !== 1'b0) begin
      n_fail++; $display("FAIL mul_no_restart: stall %b expected 0", bus.Stall_o);
    end
  endtask

  task automatic test_flush_mul();
    int busy;
    busy = 0;
    drive_op(3'b011, 32'd7, 32'd3, 5'd2);
    for (int i = 0; i < 100 && busy < 10; i++) begin
      tick();
      if (bus.Stall_o === 1'b1) busy++;
    end
    bus.Flush_i = 1;
    #1;
    n_checks++;
    if (bus.Stall_o !== 1'b0 || busy != 10) begin
      n_fail++; $display("FAIL flush_stall: stall %b busy %0d expected 0 10", bus.Stall_o, busy);
    end
    tick();
    n_checks++;
    if (bus.EXMEM_RegWrite_o !== 1'b0 || bus.EXMEM_ALUResult_o !== '0 || bus.EXMEM_RD_o !== 5'd0) begin
      n_fail++; $display("FAIL flush_bubble: rw %b result %h rd %0d expected 0 0 0",
        bus.EXMEM_RegWrite_o, bus.EXMEM_ALUResult_o, bus.EXMEM_RD_o);
    end
    drive_op(3'b010, 32'd10, 32'd20, 5'd4);
    #1;
    n_checks++;
    if (bus.Stall_o !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: stall %b expected 0", bus.Stall_o);
    end
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'd30 || bus.EXMEM_RegWrite_o !== 1'b1 || bus.EXMEM_RD_o !== 5'd4) begin
      n_fail++; $display("FAIL flush_then_add: result %h rw %b rd %0d expected 0000001e 1 4",
        bus.EXMEM_ALUResult_o, bus.EXMEM_RegWrite_o, bus.EXMEM_RD_o);
    end
    $display("flush at busy 10, then ADD 10+20 -> %h", bus.EXMEM_ALUResult_o);
    drive_nop();
  endtask

  task automatic test_slt_bubble();
    drive_op(3'b111, 32'hFFFF_FFFF, 32'd1, 5'd6);
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'd1) begin
      n_fail++; $display("FAIL slt_neg: got %h expected 00000001", bus.EXMEM_ALUResult_o);
    end
    drive_op(3'b111, 32'd1, 32'hFFFF_FFFF, 5'd6);
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'd0) begin
      n_fail++; $display("FAIL slt_pos: got %h expected 00000000", bus.EXMEM_ALUResult_o);
    end
    drive_op(3'b010, 32'd8, 32'd9, 5'd5);
    bus.IDEX_Valid_i = 0; bus.IDEX_MemRead_i = 1; bus.IDEX_MemtoReg_i = 1;
    tick();
    n_checks++;
    if (bus.EXMEM_RegWrite_o !== 1'b0 || bus.EXMEM_RD_o !== 5'd0 || bus.EXMEM_MemRead_o !== 1'b0 ||
        bus.EXMEM_ALUResult_o !== '0) begin
      n_fail++; $display("FAIL bubble_invalid: rw %b rd %0d mr %b result %h expected 0 0 0 0",
        bus.EXMEM_RegWrite_o, bus.EXMEM_RD_o, bus.EXMEM_MemRead_o, bus.EXMEM_ALUResult_o);
    end
    bus.IDEX_Valid_i = 1; bus.Flush_i = 1;
    tick();
    n_checks++;
    if (bus.EXMEM_RegWrite_o !== 1'b0 || bus.EXMEM_MemtoReg_o !== 1'b0 || bus.EXMEM_ALUResult_o !== '0) begin
      n_fail++; $display("FAIL bubble_flush: rw %b m2r %b result %h expected 0 0 0",
        bus.EXMEM_RegWrite_o, bus.EXMEM_MemtoReg_o, bus.EXMEM_ALUResult_o);
    end
    $display("SLT and bubble cases checked");
    drive_nop();
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    logic [31:0] exp [5] = '{32'h0000_F000, 32'h0000_FFF0, 32'd99, 32'h0000_FF63, 32'hFFFF_FFFF};
    for (int i = 0; i < 5; i++) begin
      drive_op(ops[i], 32'h0000_F0F0, 32'h0000_FF00, 5'(i + 10));
      if (i == 2) begin bus.IDEX_RSData_i = 32'd100; bus.IDEX_ALUSrc_i = 1; bus.IDEX_Imm_i = 32'hFFFF_FFFF; end
      if (i == 3) bus.IDEX_RSData_i = 32'h63;
      if (i == 4) begin bus.IDEX_RSData_i = 32'hFFFF_FFF0; bus.IDEX_RTData_i = 32'hF; end
      tick();
      n_checks++;
      if (bus.EXMEM_ALUResult_o !== exp[i] || bus.EXMEM_RD_o !== 5'(i + 10)) begin
        n_fail++; $display("FAIL b2b_op%0d: result %h rd %0d expected %h %0d",
          i, bus.EXMEM_ALUResult_o, bus.EXMEM_RD_o, exp[i], i + 10);
      end
      $display("b2b op %b -> %h", ops[i], bus.EXMEM_ALUResult_o);
    end
    drive_nop();
  endtask

  task automatic test_overflow();
    logic exp_rw;
`ifdef EX_OVF_TRAP_EN
    exp_rw = 1'b0;
`else
    exp_rw = 1'b1;
`endif
    drive_op(3'b010, 32'h7FFF_FFFF, 32'd1, 5'd8);
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'h8000_0000 || bus.EXMEM_RegWrite_o !== exp_rw) begin
      n_fail++; $display("FAIL ovf_add: result %h rw %b expected 80000000 %b",
        bus.EXMEM_ALUResult_o, bus.EXMEM_RegWrite_o, exp_rw);
    end
`ifdef EX_OVF_TRAP_EN
    n_checks++;
    if (bus.Ovf_o !== 1'b1) begin
      n_fail++; $display("FAIL ovf_flag_add: got %b expected 1", bus.Ovf_o);
    end
`endif
    drive_op(3'b110, 32'h8000_0000, 32'd1, 5'd8);
    tick();
    n_checks++;
    if (bus.EXMEM_ALUResult_o !== 32'h7FFF_FFFF || bus.EXMEM_RegWrite_o !== exp_rw) begin
      n_fail++; $display("FAIL ovf_sub: result %h rw %b expected 7fffffff %b",
        bus.EXMEM_ALUResult_o, bus.EXMEM_RegWrite_o, exp_rw);
    end
    drive_op(3'b010, 32'd1, 32'd1, 5'd8);
    tick();
    n_checks++;
    if (bus.EXMEM_RegWrite_o !== 1'b1 || bus.EXMEM_ALUResult_o !== 32'd2) begin
      n_fail++; $display("FAIL ovf_clear: rw %b result %h expected 1 00000002",
        bus.EXMEM_RegWrite_o, bus.EXMEM_ALUResult_o);
    end
`ifdef EX_OVF_TRAP_EN
    n_checks++;
    if (bus.Ovf_o !== 1'b0) begin
      n_fail++; $display("FAIL ovf_flag_clear: got %b expected 0", bus.Ovf_o);
    end
`endif
    $display("overflow cases checked, expected regwrite on overflow %b", exp_rw);
    drive_nop();
  endtask

  initial begin
    drive_nop();
    test_reset();
    test_forwarding();
    test_mul();
    test_flush_mul();
    test_slt_bubble();
    test_back_to_back();
    test_overflow();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
